// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the 64-bit byte-serial data-memory responder.
// Holds no logic, so it adds no latency and has no backpressure.
package dmem_pkg;

    localparam int DMEM_ADDR_BITS = 10;
    localparam int DMEM_BEATS     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_shift64.sv
// 64-bit word register that loads in parallel or shifts one byte in at the LSB end.
// Updates one cycle after load/shift_en; it has no backpressure and does whatever it is told each cycle.
module dmem_shift64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_dat,
    input  logic        shift_en,
    input  logic [7:0]  shift_dat,
    output logic [63:0] word_dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_dat <= '0;
        end else if (load) begin
            word_dat <= load_dat;
        end else if (shift_en) begin
            word_dat <= {word_dat[55:0], shift_dat};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Serves 64-bit loads and stores over a byte-wide synchronous memory, big-endian, one byte per cycle.
// Store response at T+9 and load response at T+10; stall holds the requester from acceptance until the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = DMEM_ADDR_BITS,
    parameter int BEATS     = DMEM_BEATS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [63:0]          req_addr,
    input  logic [63:0]          req_wdata,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [63:0]          resp_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    dmem_state_t          state;
    dmem_state_t          state_nxt;
    logic [2:0]           beat_cnt;
    logic                 rd_tail;
    logic                 last_beat;
    logic [ADDR_BITS-1:0] base_q;
    logic [63:0]          rdata_q;
    logic [63:0]          word_dat;
    logic                 load;
    logic                 shift_en;
    logic [7:0]           shift_dat;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^req_addr[63:ADDR_BITS];
    assign last_beat      = (beat_cnt == 3'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reads need one extra cycle after the last address for the final byte to return.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_write ? WRITE : READ;
            WRITE:   if (last_beat) state_nxt = DONE;
            READ:    if (rd_tail)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        load       = 1'b0;
        shift_en   = 1'b0;
        shift_dat  = mem_rdata;
        case (state)
            IDLE: begin
                stall = req_valid;
                load  = req_valid;
            end
            WRITE: begin
                // Rotating the top byte back in leaves the store word intact for the response.
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_BITS'(beat_cnt);
                mem_wdata = word_dat[63:56];
                shift_en  = 1'b1;
                shift_dat = word_dat[63:56];
            end
            READ: begin
                stall    = 1'b1;
                mem_addr = base_q + ADDR_BITS'(beat_cnt);
                shift_en = (beat_cnt != 3'd0) || rd_tail;
            end
            DONE: begin
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign resp_rdata = (state == DONE) ? word_dat : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            rd_tail  <= 1'b0;
            base_q   <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    rd_tail  <= 1'b0;
                    if (req_valid) base_q <= req_addr[ADDR_BITS-1:0];
                end
                WRITE: beat_cnt <= beat_cnt + 3'd1;
                READ: begin
                    if (!rd_tail) beat_cnt <= beat_cnt + 3'd1;
                    rd_tail <= last_beat && !rd_tail;
                end
                DONE: rdata_q <= word_dat;
                default: ;
            endcase
        end
    end

    dmem_shift64 u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_dat  (req_wdata),
        .shift_en  (shift_en),
        .shift_dat (shift_dat),
        .word_dat  (word_dat)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte memory, directed cases and random traffic against a timing/arithmetic model.
module tb_dmem_responder;

    localparam int AB = 10;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          req_valid  = 1'b0;
    logic          req_write  = 1'b0;
    logic [63:0]   req_addr   = '0;
    logic [63:0]   req_wdata  = '0;
    logic          stall;
    logic          resp_valid;
    logic [63:0]   resp_rdata;
    logic [AB-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata  = 8'h00;

    dmem_responder #(.ADDR_BITS(AB), .BEATS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_evt = 0;
    always @(negedge rst_n) rst_evt <= rst_evt + 1;

    // Backing byte memory with a bench-side preload port.
    logic [7:0]    mem [1024] = '{default: 8'h00};
    logic          tb_we   = 1'b0;
    logic [AB-1:0] tb_addr = '0;
    logic [7:0]    tb_dat  = 8'h00;
    always @(posedge clk) begin
        if (tb_we)       mem[tb_addr]  <= tb_dat;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model state
    logic [7:0]  ref_mem [1024] = '{default: 8'h00};
    logic        m_busy = 1'b0;
    logic        m_wr   = 1'b0;
    int          m_base = 0;
    int          m_t0   = 0;
    logic [63:0] m_wd   = '0;
    logic [63:0] m_hold = '0;
    int          resp_cnt  = 0;
    int          resp_cyc  = 0;
    logic [63:0] resp_dat  = '0;
    int          stall_cnt = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd, output int t);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        t = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_resp(input int target, input string nm);
        int k = 0;
        while (resp_cnt < target && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        chk(nm, 64'(resp_cnt), 64'(target));
    endtask

    initial begin
        fork
            begin : compare
                int d, a, rst_seen;
                logic [63:0] e_rd;
                logic e_stall, e_rv, e_we;
                rst_seen = 0;
                forever begin
                    @(negedge clk);
                    if (tb_we) ref_mem[tb_addr] = tb_dat;
                    if (stall) stall_cnt++;
                    if (resp_valid) begin
                        resp_cnt++;
                        resp_cyc = cyc;
                        resp_dat = resp_rdata;
                    end
                    if (!rst_n || rst_evt != rst_seen) begin
                        rst_seen = rst_evt;
                        m_busy   = 1'b0;
                        m_hold   = '0;
                    end
                    e_stall = 1'b0;
                    e_rv    = 1'b0;
                    e_we    = 1'b0;
                    e_rd    = m_hold;
                    if (!rst_n) begin
                        e_stall = req_valid;
                        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
                        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
                    end else if (m_busy) begin
                        d = cyc - m_t0;
                        e_stall = 1'b1;
                        if (d >= 1 && d <= 8) begin
                            a = (m_base + d - 1) % 1024;
                            chk("mem_addr", 64'(mem_addr), 64'(a));
                            if (m_wr) begin
                                e_we = 1'b1;
                                chk("mem_wdata", 64'(mem_wdata), 64'(8'(m_wd >> (8 * (8 - d)))));
                                ref_mem[a] = 8'(m_wd >> (8 * (8 - d)));
                            end
                        end
                        if ((m_wr && d == 9) || (!m_wr && d == 10)) begin
                            e_stall = 1'b0;
                            e_rv    = 1'b1;
                            e_rd    = m_wd;
                            m_hold  = m_wd;
                            m_busy  = 1'b0;
                        end
                    end else begin
                        e_stall = req_valid;
                        if (req_valid) begin
                            m_busy = 1'b1;
                            m_t0   = cyc;
                            m_wr   = req_write;
                            m_base = int'(req_addr[AB-1:0]);
                            if (req_write) begin
                                m_wd = req_wdata;
                            end else begin
                                for (int k = 0; k < 8; k++)
                                    m_wd = {m_wd[55:0], ref_mem[(m_base + k) % 1024]};
                            end
                        end
                    end
                    chk("stall", 64'(stall), 64'(e_stall));
                    chk("resp_valid", 64'(resp_valid), 64'(e_rv));
                    chk("mem_we", 64'(mem_we), 64'(e_we));
                    chk("resp_rdata", resp_rdata, e_rd);
                end
            end
            begin : stim
                int t, n, s0, bad;
                logic [63:0] w;

                // Reset values while rst_n is low
                #1 rst_n = 1'b0;
                #2;
                chk("reset_stall", 64'(stall), 64'd0);
                chk("reset_resp_valid", 64'(resp_valid), 64'd0);
                chk("reset_mem_we", 64'(mem_we), 64'd0);
                chk("reset_mem_addr", 64'(mem_addr), 64'd0);
                chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
                chk("reset_resp_rdata", resp_rdata, 64'd0);
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;

                @(posedge clk); #1;
                tb_we = 1'b1; tb_addr = 10'd7; tb_dat = 8'h80;
                @(posedge clk); #1;
                tb_we = 1'b0;

                // Load at 0 sees the preloaded byte in the last lane
                s0 = stall_cnt; n = resp_cnt;
                issue(1'b0, 64'h0, 64'h0, t);
                wait_resp(n + 1, "ld0_count");
                chk("ld0_latency", 64'(resp_cyc - t), 64'd10);
                chk("ld0_data", resp_dat, 64'h0000000000000080);
                chk("ld0_stall_cycles", 64'(stall_cnt - s0), 64'd10);

                // Big-endian store, then reload
                w = 64'h0123456789ABCDEF;
                n = resp_cnt;
                issue(1'b1, 64'h10, w, t);
                wait_resp(n + 1, "st10_count");
                chk("st10_latency", 64'(resp_cyc - t), 64'd9);
                chk("st10_rdata", resp_dat, 64'h0123456789ABCDEF);
                for (int k = 0; k < 8; k++)
                    chk("st10_mem", 64'(mem[16 + k]), 64'(w[63 - 8 * k -: 8]));
                n = resp_cnt;
                issue(1'b0, 64'h10, 64'h0, t);
                wait_resp(n + 1, "ld10_count");
                chk("ld10_data", resp_dat, 64'h0123456789ABCDEF);

                // Store wrapping past the top of memory
                w = 64'h1122334455667788;
                n = resp_cnt;
                issue(1'b1, 64'h3FE, w, t);
                wait_resp(n + 1, "wrap_st_count");
                for (int k = 0; k < 8; k++)
                    chk("wrap_mem", 64'(mem[(1022 + k) % 1024]), 64'(w[63 - 8 * k -: 8]));
                n = resp_cnt;
                issue(1'b0, 64'h3FE, 64'h0, t);
                wait_resp(n + 1, "wrap_ld_count");
                chk("wrap_ld_data", resp_dat, 64'h1122334455667788);

                // Upper address bits ignored
                n = resp_cnt;
                issue(1'b0, 64'hFFFF000000000007, 64'h0, t);
                wait_resp(n + 1, "hi_addr_count");
                chk("hi_addr_data", resp_dat, 64'h8000000000000000);
                n = resp_cnt;
                issue(1'b0, 64'h7, 64'h0, t);
                wait_resp(n + 1, "lo_addr_count");
                chk("lo_addr_data", resp_dat, 64'h8000000000000000);

                // Reset during the fourth store beat
                n = resp_cnt;
                issue(1'b1, 64'h20, 64'hAABBCCDDEEFF0011, t);
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("abort_mem_we", 64'(mem_we), 64'd0);
                chk("abort_resp_valid", 64'(resp_valid), 64'd0);
                chk("abort_stall", 64'(stall), 64'd0);
                #1 rst_n = 1'b1;
                issue(1'b0, 64'h20, 64'h0, t);
                wait_resp(n + 1, "abort_count");
                w = 64'hAABBCC0000000000;
                chk("abort_ld_data", resp_dat, w);
                for (int k = 0; k < 8; k++)
                    chk("abort_mem", 64'(mem[32 + k]), 64'(w[63 - 8 * k -: 8]));

                // req_valid held through DONE
                n = resp_cnt;
                @(posedge clk); #1;
                req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
                t = cyc;
                repeat (12) @(posedge clk);
                #1 req_valid = 1'b0;
                wait_resp(n + 2, "held_count");
                chk("held_second_latency", 64'(resp_cyc - t), 64'd21);
                chk("held_data", resp_dat, 64'h0123456789ABCDEF);

                // Random traffic with two asynchronous resets
                for (int i = 0; i < 1500; i++) begin
                    @(posedge clk); #1;
                    req_valid = ($urandom_range(0, 2) == 0);
                    req_write = 1'($urandom);
                    req_addr  = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0)
                        req_addr[AB-1:0] = 10'h3F8 + 10'($urandom_range(0, 15));
                    req_wdata = {$urandom, $urandom};
                    if (i == 700 || i == 1100) begin
                        #1 rst_n = 1'b0;
                        #1 rst_n = 1'b1;
                    end
                end
                @(posedge clk); #1;
                req_valid = 1'b0;
                repeat (15) @(posedge clk);
                #1;

                bad = 0;
                for (int k = 0; k < 1024; k++)
                    if (mem[k] !== ref_mem[k]) bad++;
                chk("mem_image", 64'(bad), 64'd0);

                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10; width of the backing byte-memory address.
REQ-002 SHALL have parameter BEATS, default 8; bytes per access, fixed at 8 for 64-bit words.
REQ-003 SHALL have port clk, input, 1 bit; the only clock, with all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit; Mbox presents an access this cycle.
REQ-006 SHALL have port req_write, input, 1 bit; 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 64 bits; byte address, with only [ADDR_BITS-1:0] used.
REQ-008 SHALL have port req_wdata, input, 64 bits; store data.
REQ-009 SHALL have port stall, output, 1 bit; Mbox must hold its pipeline while high.
REQ-010 SHALL have port resp_valid, output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 64 bits; load result, valid with resp_valid.
REQ-012 SHALL have port mem_addr, output, ADDR_BITS bits; backing byte-memory address.
REQ-013 SHALL have port mem_we, output, 1 bit; byte write enable, sampled by the memory at the rising edge.
REQ-014 SHALL have port mem_wdata, output, 8 bits; byte to write.
REQ-015 SHALL have port mem_rdata, input, 8 bits; synchronous-read byte, valid one cycle after mem_addr.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ and DONE.
REQ-017 IDLE transitions: req_valid=1 at cycle T accepts the request and latches addr[ADDR_BITS-1:0], write and wdata; the FSM enters WRITE or READ at T+1.
REQ-018 stall SHALL equal (state==IDLE && req_valid) || state==WRITE || state==READ; stall SHALL be 0 in DONE.
REQ-019 WRITE: at cycles T+1..T+8 (beat k=0..7), mem_we=1, mem_addr=base+k and mem_wdata=wdata[63-8k -: 8] (big-endian); the FSM enters DONE at T+9.
REQ-020 READ: at cycles T+1..T+8, mem_addr=base+k and mem_we=0; the byte returned at T+2+k SHALL be placed in resp_rdata[63-8k -: 8]; the FSM enters DONE at T+10.
REQ-021 DONE: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-022 A store in DONE SHALL drive resp_rdata equal to the stored word.
REQ-023 A load in DONE SHALL drive resp_rdata equal to the assembled word.
REQ-024 base+k SHALL wrap modulo 2^ADDR_BITS; unaligned addresses are legal.
REQ-025 All req_* inputs SHALL be ignored outside IDLE, including req_valid asserted in DONE.
REQ-026 resp_rdata SHALL hold its value after DONE until the next completion.
REQ-027 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, stall=0 (unless req_valid=1), resp_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_rdata=0 and the beat counter=0.
REQ-029 Reset mid-access SHALL abort the access with no response; bytes already committed stay in memory, and no further bytes are written.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum, DMEM_ADDR_BITS=10 and DMEM_BEATS=8.
REQ-031 The 64-bit beat shift/assemble register SHALL be sub-module dmem_shift64; the FSM and the 3-bit beat counter stay in dmem_responder.

Verification
REQ-032 Preload mem[7]=0x80, then load at addr 0 (req at T) -> stall=1 at T..T+9, resp_valid at T+10, resp_rdata=0x0000000000000080.
REQ-033 Store 0x0123456789ABCDEF at addr 0x10 -> mem[0x10..0x17]=01,23,45,67,89,AB,CD,EF; resp_valid at T+9; a subsequent load returns the same word.
REQ-034 Store 0x1122334455667788 at addr 0x3FE -> bytes land at 0x3FE, 0x3FF, 0x000..0x005 (wrap); reload from 0x3FE matches.
REQ-035 Load from addr 0xFFFF000000000007 -> identical result to a load from 0x007; req_addr changed during stall has no effect.
REQ-036 Store at 0x20, with rst_n low during cycle T+4 -> only mem[0x20..0x22] updated, mem_we=0 immediately, no resp_valid; a request at the first cycle after release is serviced normally.
REQ-037 req_valid held high through DONE -> the second request is accepted only in the following IDLE cycle; exactly two resp_valid pulses.
